// File: rtl/sram_arbiter_if.sv
// Requester-side and SRAM-side signal bundle for sram_arbiter.
// slave is the arbiter's view; master is the requesters plus SRAM macro.
interface sram_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_write;
  logic [NUM_REQ-1:0][31:0] req_addr;
  logic [NUM_REQ-1:0][31:0] req_wdata;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [31:0]              resp_rdata;
  logic                     resp_err;
  logic                     mem_cs;
  logic                     mem_we_n;
  logic [31:0]              mem_addr;
  logic [31:0]              mem_wdata;
  logic [31:0]              mem_rdata;
  logic                     mem_resp;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_resp,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_cs, mem_we_n, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_resp,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_cs, mem_we_n, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port word SRAM between NUM_REQ requesters.
// Each access runs IDLE -> ACCESS -> COMPLETE; out-of-range addresses skip ACCESS.
module sram_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 1024
) (
  input logic           clk,
  input logic           reset,
  sram_arbiter_if.slave arb_if
);
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]       owner_q;
  logic                write_q;
  logic                oor_q;
  logic [31:0]         rdata_q;
  logic                mem_cs_q, mem_we_n_q;
  logic [31:0]         mem_addr_q, mem_wdata_q;

  logic [PW-1:0]       winner, idx;
  logic                found;
  logic                any_req, handshake;
  logic [31:0]         win_addr;
  logic                win_oor;
  logic [NUM_REQ-1:0]  req_ready, resp_valid;
  logic [31:0]         resp_rdata;
  logic                resp_err;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    idx    = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && arb_if.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign any_req   = |arb_if.req_valid;
  assign handshake = (state_q == IDLE) && any_req;
  assign win_addr  = arb_if.req_addr[winner];
  assign win_oor   = win_addr >= 32'(DEPTH);
  assign rr_ptr_d  = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (any_req) state_d = win_oor ? COMPLETE : ACCESS;
      ACCESS:   state_d = COMPLETE;
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state_q)
      IDLE: if (any_req) req_ready[winner] = 1'b1;
      COMPLETE: begin
        resp_valid[owner_q] = 1'b1;
        if (oor_q)        resp_err   = 1'b1;
        else if (write_q) resp_err   = ~arb_if.mem_resp;
        else              resp_rdata = rdata_q;
      end
      default: ;
    endcase
  end

  // SRAM port is registered so the macro sees clean levels for the whole ACCESS cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      write_q     <= 1'b0;
      oor_q       <= 1'b0;
      rdata_q     <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_n_q  <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_cs_q   <= 1'b0;
      mem_we_n_q <= 1'b1;
      if (handshake) begin
        rr_ptr_q <= rr_ptr_d;
        owner_q  <= winner;
        write_q  <= arb_if.req_write[winner];
        oor_q    <= win_oor;
        if (!win_oor) begin
          mem_cs_q    <= 1'b1;
          mem_we_n_q  <= ~arb_if.req_write[winner];
          mem_addr_q  <= win_addr;
          mem_wdata_q <= arb_if.req_wdata[winner];
        end
      end
      if (state_q == ACCESS && !write_q) rdata_q <= arb_if.mem_rdata;
    end
  end

  assign arb_if.req_ready  = req_ready;
  assign arb_if.resp_valid = resp_valid;
  assign arb_if.resp_rdata = resp_rdata;
  assign arb_if.resp_err   = resp_err;
  assign arb_if.mem_cs     = mem_cs_q;
  assign arb_if.mem_we_n   = mem_we_n_q;
  assign arb_if.mem_addr   = mem_addr_q;
  assign arb_if.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM macro model, transaction-level reference, directed and random steps.
module tb_sram_arbiter;
  localparam int N     = 4;
  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if #(.NUM_REQ(N)) ifc ();
  sram_arbiter #(.NUM_REQ(N), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .arb_if(ifc));

  // SRAM macro: combinational read, write on the edge, ack the cycle after.
  bit [31:0] sram [DEPTH];
  bit        nack = 1'b0;
  assign ifc.mem_rdata = (ifc.mem_addr < DEPTH) ? sram[ifc.mem_addr[AW-1:0]] : 32'hBAD0BAD0;
  always @(posedge clk) begin
    if (ifc.mem_cs && !ifc.mem_we_n && ifc.mem_addr < DEPTH)
      sram[ifc.mem_addr[AW-1:0]] <= ifc.mem_wdata;
    ifc.mem_resp <= ifc.mem_cs && !ifc.mem_we_n && !nack;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  bit [31:0]   ref_mem [DEPTH];
  bit          r_wr [N];
  logic [31:0] r_addr [N];
  logic [31:0] r_data [N];
  int          reps [N];
  logic [N-1:0] pend = '0;
  int          m_ptr = 0;
  int          order [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    ifc.req_valid = '0;
    pend = '0;
    @(posedge clk);
    step();
    reset = 1'b0;
    m_ptr = 0;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input int n);
    ifc.req_valid[i] = 1'b1;
    ifc.req_write[i] = wr;
    ifc.req_addr[i]  = a;
    ifc.req_wdata[i] = d;
    r_wr[i] = wr; r_addr[i] = a; r_data[i] = d; reps[i] = n;
    pend[i] = 1'b1;
  endtask

  // Serve every pending request, checking arbitration order, spacing and each response.
  task automatic serve_pending();
    int w, n, gcyc, last_cyc;
    bit have_last, last_oor, oor;
    logic [N-1:0] oh;
    have_last = 1'b0; last_cyc = 0; last_oor = 1'b0;
    order.delete();
    while (pend != '0) begin
      w = 0;
      for (int k = N - 1; k >= 0; k--) if (pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      oh = '0; oh[w] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (ifc.req_ready == '0 && n < 12);
      chk("grant", 32'(ifc.req_ready), 32'(oh));
      if (ifc.req_ready !== oh) begin
        ifc.req_valid = '0; pend = '0;
        return;
      end
      order.push_back(w);
      gcyc = cyc;
      if (have_last) chk("gap", gcyc - last_cyc, last_oor ? 2 : 3);
      oor = r_addr[w] >= DEPTH;
      step();
      if (reps[w] > 1) reps[w]--;
      else begin ifc.req_valid[w] = 1'b0; pend[w] = 1'b0; end
      m_ptr = (w + 1) % N;
      @(negedge clk);
      if (oor) begin
        chk("oor_cs", ifc.mem_cs, 0);
        chk("oor_rvalid", 32'(ifc.resp_valid), 32'(oh));
        chk("oor_err", ifc.resp_err, 1);
        chk("oor_rdata", ifc.resp_rdata, 0);
      end else begin
        chk("acc_cs", ifc.mem_cs, 1);
        chk("acc_we_n", ifc.mem_we_n, !r_wr[w]);
        chk("acc_addr", ifc.mem_addr, r_addr[w]);
        if (r_wr[w]) chk("acc_wdata", ifc.mem_wdata, r_data[w]);
        chk("acc_rvalid", 32'(ifc.resp_valid), 0);
        if (r_wr[w]) ref_mem[r_addr[w][AW-1:0]] = r_data[w];
        @(negedge clk);
        chk("cmp_rvalid", 32'(ifc.resp_valid), 32'(oh));
        chk("cmp_err", ifc.resp_err, r_wr[w] & nack);
        chk("cmp_rdata", ifc.resp_rdata, r_wr[w] ? 32'h0 : ref_mem[r_addr[w][AW-1:0]]);
        chk("cmp_cs", ifc.mem_cs, 0);
      end
      have_last = 1'b1; last_cyc = gcyc; last_oor = oor;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] mask;
    ifc.req_valid = '0; ifc.req_write = '0; ifc.req_addr = '0; ifc.req_wdata = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(ifc.req_ready), 0);
    chk("rst_rvalid", 32'(ifc.resp_valid), 0);
    chk("rst_rdata", ifc.resp_rdata, 0);
    chk("rst_err", ifc.resp_err, 0);
    chk("rst_cs", ifc.mem_cs, 0);
    chk("rst_we_n", ifc.mem_we_n, 1);
    chk("rst_addr", ifc.mem_addr, 0);
    chk("rst_wdata", ifc.mem_wdata, 0);

    // Write then read back word 5 from another requester
    step(); set_req(0, 1'b1, 32'd5, 32'hDEADBEEF, 1); serve_pending();
    step(); set_req(1, 1'b0, 32'd5, 32'h0, 1); serve_pending();
    chk("rb_sram", sram[5], 32'hDEADBEEF);

    // Two contending readers, two reads each
    do_reset();
    set_req(0, 1'b0, 32'd5, 0, 2); set_req(1, 1'b0, 32'd6, 0, 2);
    serve_pending();
    chk("rr_len", order.size(), 4);
    if (order.size() == 4) begin
      chk("rr_o0", order[0], 0); chk("rr_o1", order[1], 1);
      chk("rr_o2", order[2], 0); chk("rr_o3", order[3], 1);
    end

    // Out-of-range read at exactly DEPTH
    step(); set_req(2, 1'b0, 32'd1024, 0, 1); serve_pending();

    // Missing write ack, then a normal ack
    nack = 1'b1; step(); set_req(0, 1'b1, 32'd20, 32'h0BAD_F00D, 1); serve_pending();
    nack = 1'b0; step(); set_req(0, 1'b1, 32'd21, 32'h600D_F00D, 1); serve_pending();

    // Reset during ACCESS of a read from req0
    step(); set_req(0, 1'b0, 32'd5, 0, 1);
    @(negedge clk);
    chk("mr_grant", 32'(ifc.req_ready), 32'h1);
    step(); ifc.req_valid = '0; pend = '0; reset = 1'b1;
    @(negedge clk);
    chk("mr_cs", ifc.mem_cs, 1);
    step(); reset = 1'b0; m_ptr = 0;
    @(negedge clk);
    chk("mr_rvalid", 32'(ifc.resp_valid), 0);
    chk("mr_cs_after", ifc.mem_cs, 0);
    chk("mr_we_n", ifc.mem_we_n, 1);
    chk("mr_addr", ifc.mem_addr, 0);
    chk("mr_rdata", ifc.resp_rdata, 0);
    @(negedge clk);
    chk("mr_rvalid2", 32'(ifc.resp_valid), 0);
    step(); set_req(0, 1'b0, 32'd21, 0, 1); set_req(1, 1'b0, 32'd20, 0, 1);
    serve_pending();
    chk("mr_first", order.size() > 0 ? order[0] : -1, 0);

    // Pointer moved to 2, then req1 and req3 contend
    do_reset();
    set_req(1, 1'b0, 32'd3, 0, 1); serve_pending();
    step(); set_req(1, 1'b0, 32'd4, 0, 1); set_req(3, 1'b0, 32'd5, 0, 2);
    serve_pending();
    chk("p2_len", order.size(), 3);
    if (order.size() == 3) begin
      chk("p2_o0", order[0], 3); chk("p2_o1", order[1], 1); chk("p2_o2", order[2], 3);
    end

    // req2 raises and drops valid while the arbiter is busy
    step(); ifc.req_valid[1] = 1'b1; ifc.req_write[1] = 1'b0; ifc.req_addr[1] = 32'd7;
    @(negedge clk);
    chk("de_grant", 32'(ifc.req_ready), 32'h2);
    step();
    ifc.req_valid[1] = 1'b0;
    ifc.req_valid[2] = 1'b1; ifc.req_write[2] = 1'b1;
    ifc.req_addr[2] = 32'd9; ifc.req_wdata[2] = 32'h1234_5678;
    @(negedge clk);
    chk("de_cs", ifc.mem_cs, 1);
    chk("de_addr", ifc.mem_addr, 7);
    step(); ifc.req_valid[2] = 1'b0;
    @(negedge clk);
    chk("de_rvalid", 32'(ifc.resp_valid), 32'h2);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("de_idle_cs", ifc.mem_cs, 0);
      chk("de_idle_ready", 32'(ifc.req_ready), 0);
    end
    chk("de_sram9", sram[9], ref_mem[9]);
    m_ptr = 2;

    // Random contention rounds
    for (int r = 0; r < 40; r++) begin
      step();
      mask = N'($urandom_range(1, (1 << N) - 1));
      nack = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          logic [31:0] a;
          case ($urandom_range(0, 9))
            0:       a = 32'(DEPTH) + 32'($urandom_range(0, 3));
            1:       a = 32'hFFFF_FFF0;
            default: a = 32'($urandom_range(0, 15));
          endcase
          set_req(i, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 2));
        end
      end
      serve_pending();
    end
    nack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Round-robin arbiter and access sequencer that shares one single-port word SRAM between `NUM_REQ` requesters. It sits between the requester-side logic (for example, separate AXI read and write channel engines) and the SRAM macro port: chip-select, active-low write-enable, address, write data, read data and write response. It serialises accesses, range-checks addresses and returns per-requester completions with read data and error status.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `DEPTH`, 1024: SRAM depth in 32-bit words; addresses are word indices.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_write` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ*32: word address; requester i uses bits [32i+31:32i].
- `req_wdata` in NUM_REQ*32: write data, same packing as `req_addr`.
- `req_ready` out NUM_REQ: accept strobe, one-hot or zero.
- `resp_valid` out NUM_REQ: completion pulse, one-hot or zero.
- `resp_rdata` out 32: read data; valid with `resp_valid`.
- `resp_err` out 1: error flag; valid with `resp_valid`.
- `mem_cs` out 1: SRAM chip select.
- `mem_we_n` out 1: SRAM write enable, active low.
- `mem_addr` out 32: SRAM address.
- `mem_wdata` out 32: SRAM write data.
- `mem_rdata` in 32: SRAM read data, combinational from `mem_addr`.
- `mem_resp` in 1: SRAM write acknowledge, high for the cycle after the write edge.

## Operation
- FSM states: IDLE, ACCESS, COMPLETE.
- IDLE
  - Winner = first i with `req_valid[i]`=1, searching from `rr_ptr` upward and wrapping modulo NUM_REQ.
  - `req_ready[winner]`=1, driven combinationally from the state and `req_valid`.
  - On the handshake: latch owner, write, addr and wdata; set `rr_ptr` = (winner+1) mod NUM_REQ.
  - If addr < DEPTH, go to ACCESS. Otherwise go to COMPLETE with the error flag set.
- ACCESS (1 cycle)
  - `mem_cs`=1, `mem_we_n`=~write, `mem_addr`=latched addr, `mem_wdata`=latched wdata. All are registered outputs.
  - Read: capture `mem_rdata` into `resp_rdata` at the closing edge.
  - Always go to COMPLETE.
- COMPLETE (1 cycle)
  - `resp_valid[owner]`=1.
  - `resp_err`: write → ~`mem_resp`; read → 0; out-of-range → 1.
  - `resp_rdata` = captured data for a read; 0 for writes and for errors.
  - Always go to IDLE.
- Outside ACCESS: `mem_cs`=0, `mem_we_n`=1, `mem_addr`/`mem_wdata` hold their last values.
- Requesters must hold `req_*` stable while `req_valid`=1 until the `req_ready` handshake. Dropping `req_valid` early is legal; no access is made.
- `req_ready` is 0 in ACCESS and COMPLETE. New requests arriving then wait, and arbitration happens in the next IDLE cycle.
- Addresses of DEPTH or above never reach the SRAM, so there is no aliasing through the macro's address masking.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_cs`=0, `mem_we_n`=1, `mem_addr`=0, `mem_wdata`=0.
- Normal access:
  - Handshake at cycle T.
  - `mem_cs` high during T+1.
  - `resp_valid` during T+2.
  - Next handshake possible at T+3.
  - Peak throughput is 1 access per 3 cycles.
- Out-of-range access: handshake at T, `resp_valid` with `resp_err`=1 at T+1, next handshake at T+2.
- Write ack: `mem_resp` is sampled only in COMPLETE of a write; `mem_resp` in any other state is ignored.
- Simultaneous requests: exactly one grant per IDLE cycle. The pointer rotation guarantees that a continuously asserting requester waits at most NUM_REQ-1 grants.
- Reset asserted in any state:
  - Next cycle is IDLE with all outputs at their reset values.
  - An in-flight response is discarded and no `resp_valid` is issued.
  - A write clocked into the SRAM before reset remains written.
- Reset has priority over every other event in the same cycle.

## Test plan
- Write 0xDEADBEEF to word 5 from req0, then read word 5 from req1:
  - Write: `req_ready[0]` at T, `mem_cs`=1 and `mem_we_n`=0 at T+1, `resp_valid[0]`=1 with `resp_err`=0 at T+2.
  - Read: `resp_valid[1]`=1 with `resp_rdata`=0xDEADBEEF.
- req0 and req1 both held valid for 4 reads, NUM_REQ=2, after reset → grant order 0,1,0,1, with grants spaced 3 cycles apart.
- Read of addr 1024 (DEPTH=1024):
  - `mem_cs` stays 0.
  - `resp_valid` one cycle after the handshake, with `resp_err`=1 and `resp_rdata`=0.
- Write with the model forcing `mem_resp`=0 → `resp_err`=1 in COMPLETE; the following write with a normal ack → `resp_err`=0.
- Assert `reset` during ACCESS of a read:
  - No `resp_valid` is issued.
  - The next cycle shows all outputs at reset values, with `mem_we_n`=1.
  - The next grant goes to req0.
- NUM_REQ=4 with req1 and req3 held valid and `rr_ptr`=2 → grant order 3,1,3. A request whose `req_valid` drops before acceptance never produces `mem_cs`.
